// File: rtl/burst_mem_responder_if.sv
// rtl/burst_mem_responder_if.sv - pmem burst bus between the cache-line adapter and the memory responder
interface burst_mem_responder_if;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [63:0] pmem_wdata;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;
  logic        protocol_error;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp, protocol_error
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp, protocol_error
  );
endinterface

// File: rtl/burst_mem_responder.sv
// rtl/burst_mem_responder.sv - line-organised backing store serving 4-beat pmem bursts with configurable latency
module burst_mem_responder #(
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 4,
  parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
  input  logic                  clk,
  input  logic                  rst,
  burst_mem_responder_if.slave  pmem
);
  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_e;

  state_e           state_q;
  logic             op_write_q;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       beat_q;
  logic [3:0]       lat_q;
  logic             resp_q;
  logic [63:0]      rdata_q;
  logic             err_q;

  logic [255:0]     mem [DEPTH_LINES];

  logic [IDX_W-1:0] addr_idx;
  logic             req_held;
  logic             req_other;
  logic [IDX_W-1:0] rd_idx_d;
  logic [1:0]       rd_beat_d;
  logic [63:0]      rd_word_d;
  logic             wr_en_d;
  logic             unused_addr;

  assign addr_idx    = pmem.pmem_address[5+IDX_W-1:5];
  assign unused_addr = ^{pmem.pmem_address[31:5+IDX_W], pmem.pmem_address[4:0]};
  assign req_held    = op_write_q ? pmem.pmem_write : pmem.pmem_read;
  assign req_other   = op_write_q ? pmem.pmem_read  : pmem.pmem_write;

  // Word that rdata must show in the next cycle: beat 0 on burst entry, else the following beat.
  always_comb begin
    rd_idx_d  = (state_q == IDLE) ? addr_idx : idx_q;
    rd_beat_d = (state_q == BURST) ? beat_q + 2'd1 : 2'd0;
    rd_word_d = mem[rd_idx_d][{rd_beat_d, 6'd0} +: 64];
    wr_en_d   = (state_q == BURST) && op_write_q && pmem.pmem_write;
  end

  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      mem[idx_q][{beat_q, 6'd0} +: 64] <= pmem.pmem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_write_q <= 1'b0;
      idx_q      <= '0;
      beat_q     <= 2'd0;
      lat_q      <= 4'd0;
      resp_q     <= 1'b0;
      rdata_q    <= 64'd0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          resp_q <= 1'b0;
          if (pmem.pmem_read && pmem.pmem_write) begin
            err_q <= 1'b1;
          end else if (pmem.pmem_read || pmem.pmem_write) begin
            op_write_q <= pmem.pmem_write;
            idx_q      <= addr_idx;
            lat_q      <= 4'(LATENCY);
            beat_q     <= 2'd0;
            if (LATENCY == 0) begin
              state_q <= BURST;
              resp_q  <= 1'b1;
              if (!pmem.pmem_write) rdata_q <= rd_word_d;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!req_held) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end else begin
            if (req_other) err_q <= 1'b1;
            lat_q <= lat_q - 4'd1;
            if (lat_q == 4'd1) begin
              state_q <= BURST;
              resp_q  <= 1'b1;
              if (!op_write_q) rdata_q <= rd_word_d;
            end
          end
        end
        BURST: begin
          if (!req_held) begin
            state_q <= IDLE;
            resp_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            if (req_other) err_q <= 1'b1;
            if (beat_q == 2'd3) begin
              state_q <= DONE;
              resp_q  <= 1'b0;
            end else begin
              beat_q <= beat_q + 2'd1;
              if (!op_write_q) rdata_q <= rd_word_d;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          resp_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pmem.pmem_resp      = resp_q;
  assign pmem.pmem_rdata     = rdata_q;
  assign pmem.protocol_error = err_q;
endmodule

// File: doc/burst_mem_responder.md
Name: burst_mem_responder

Overview:
Synthesizable responder for the CPU's physical-memory burst interface, i.e. the far end of the cache-line adapter's pmem_* ports. It holds a line-organised backing store of 256-bit lines and serves 4-beat 64-bit read and write bursts. Latency is configurable. The team uses it in place of the behavioural memory model for FPGA/emulation runs and latency sweeps. It flags initiator protocol violations.

Parameters:
DEPTH_LINES, 256, number of 256-bit lines in the backing store (power of 2).
LATENCY, 4, idle cycles between request acceptance and the first response beat (0..15).
IDX_W, $clog2(DEPTH_LINES), line index width (derived).

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
pmem_read  input  1  read burst request, held until the 4th resp.
pmem_write  input  1  write burst request, held until the 4th resp.
pmem_address  input  32  line address; bits [4:0] ignored.
pmem_wdata  input  64  write beat data; initiator advances it after each resp.
pmem_rdata  output  64  read beat data, valid while pmem_resp=1.
pmem_resp  output  1  per-beat acknowledge.
protocol_error  output  1  sticky flag for protocol violations.

Behaviour:
- Reset (asynchronous, active-high) forces state IDLE, beat counter 0, latency counter 0, pmem_resp=0, pmem_rdata=0, protocol_error=0. Store contents are neither cleared nor affected (zero at time 0). Reset mid-burst aborts the burst; write beats already committed remain.
- Line index is pmem_address[5+IDX_W-1:5]. Higher address bits are ignored, so addresses wrap modulo DEPTH_LINES.
- Beat order is ascending: beat b maps to line bits [64b+63:64b], b=0..3.
- State machine: IDLE -> WAIT -> BURST -> DONE -> IDLE.
- IDLE: on a clock edge with exactly one of pmem_read/pmem_write high:
  - latch the operation and line index;
  - load the latency counter with LATENCY;
  - go to WAIT, or go directly to BURST if LATENCY=0.
- Both read and write high in IDLE: set protocol_error, stay IDLE, no access.
- WAIT: decrement the counter each cycle; at 0, go to BURST. The first pmem_resp is high exactly LATENCY+1 cycles after the cycle the request was first sampled.
- BURST: pmem_resp=1 for exactly 4 consecutive cycles (beats 0..3). Outputs are registered.
  - Read: pmem_rdata = beat b of the latched line, valid in the same cycle as resp.
  - Write: at each rising edge where pmem_resp=1, pmem_wdata is written into beat b. All 4 beats are committed by the edge ending beat 3. A read of the same line afterwards returns the new data.
- DONE: one cycle with resp=0 and requests ignored; then IDLE. Minimum spacing between bursts is one dead cycle.
- Request drop: if the latched request signal goes low during WAIT or BURST:
  - abort to IDLE at the next edge, resp=0;
  - set protocol_error;
  - write beats already committed remain.
- Request flips, or the opposite request rises during WAIT/BURST: protocol_error set; the burst continues with the latched operation.
- Address change during WAIT/BURST is ignored (the latched index is used).
- pmem_rdata holds its last value when resp=0. Consumers must qualify it with resp.
- protocol_error is cleared only by rst.

Test Plan:
- Reset, LATENCY=4, read of address 0x0000_0040 from a zeroed store -> resp high in cycles 6..9 after the request cycle (request cycle = 1), rdata=0 each beat, protocol_error=0.
- Write to 0x0000_0060 with beats 0x1111..11, 0x2222..22, 0x3333..33, 0x4444..44, then read of 0x0000_0060 -> rdata beats in the same order; exactly 4 resp pulses per burst; one dead cycle between bursts.
- DEPTH_LINES=256: write to 0x0000_2000 (index 0), then read of 0x0000_0000 -> returns the written data (wrap). Read of 0x0000_0065 -> same line as 0x60 (low bits ignored).
- pmem_read and pmem_write both high in IDLE -> no resp, protocol_error=1 and remains 1 after the requests drop.
- Write burst with pmem_write dropped after beat 1 -> beats 0-1 updated, beats 2-3 keep old values, protocol_error=1, state back to IDLE.
- Assert rst asynchronously during beat 2 of a read -> pmem_resp falls immediately (no clock edge); a next read after reset completes normally with LATENCY=0 timing (resp 1 cycle after the request cycle) when reconfigured.
